// File: rtl/i2c_eeprom_slave.sv
// 128x8 two-wire EEPROM target: oversampled scl/sda, START/STOP detection, LSB-first bytes.
// Optional write protect input enabled by defining EEPROM_WRITE_PROTECT_EN.
module i2c_eeprom_slave #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
`ifdef EEPROM_WRITE_PROTECT_EN
  input  logic              wp,
`endif
  output logic              busy,
  output logic              wr_done,
  output logic              rd_done,
  output logic [ADDR_W-1:0] mem_addr
);

`ifdef EEPROM_WRITE_PROTECT_EN
  localparam int N_IN = 3;
`else
  localparam int N_IN = 2;
`endif
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, ADDR_ACK, RX_DATA, DATA_ACK, TX_DATA, MST_ACK, WAIT_STOP
  } state_t;

  state_t                          state;
  logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
  logic [N_IN-1:0]                 prev_q;
  logic [N_IN-1:0]                 pins;
  logic [N_IN-1:0]                 cur;
  logic [DATA_W-1:0]               shift_q;
  logic [DATA_W-1:0]               rx_byte;
  logic [DATA_W-1:0]               rd_data;
  logic [DATA_W-1:0]               mem [2**ADDR_W];
  logic [CNT_W-1:0]                bit_cnt;
  logic                            wr_flag;
  logic                            ack_hold;
  logic                            sda_oe;
  logic                            scl_s, sda_s, scl_p, sda_p, wp_s;
  logic                            scl_rise, scl_fall, start_det, stop_det;
  logic                            mem_we;

`ifdef EEPROM_WRITE_PROTECT_EN
  assign pins = {wp, sda, scl};
  assign wp_s = cur[2];
`else
  assign pins = {sda, scl};
  assign wp_s = 1'b0;
`endif

  // Gating with rst releases the bus combinationally the moment reset asserts.
  assign sda = (sda_oe && rst) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur       = sync_q[SYNC_STAGES-1];
  assign scl_s     = cur[0];
  assign sda_s     = cur[1];
  assign scl_p     = prev_q[0];
  assign sda_p     = prev_q[1];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
  assign rx_byte   = {sda_s, shift_q[DATA_W-1:1]};

  assign mem_we = (state == RX_DATA) && scl_rise && !start_det && !stop_det &&
                  (bit_cnt == CNT_W'(DATA_W - 1)) && !wp_s;

  // Memory is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= rx_byte;
    rd_data <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      mem_addr <= '0;
      shift_q  <= '0;
      bit_cnt  <= '0;
      wr_flag  <= 1'b0;
      ack_hold <= 1'b0;
      sda_oe   <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      if (start_det) begin
        state    <= RX_ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        ack_hold <= 1'b0;
        busy     <= 1'b1;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: sda_oe <= 1'b0;
          RX_ADDR: if (scl_rise) begin
            shift_q <= rx_byte;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              mem_addr <= rx_byte[ADDR_W:1];
              wr_flag  <= rx_byte[0];
              bit_cnt  <= '0;
              ack_hold <= 1'b0;
              state    <= ADDR_ACK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!ack_hold) begin
              sda_oe   <= 1'b1;
              ack_hold <= 1'b1;
            end else begin
              ack_hold <= 1'b0;
              if (wr_flag) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= RX_DATA;
              end else begin
                sda_oe  <= ~rd_data[0];
                shift_q <= rd_data >> 1;
                bit_cnt <= CNT_W'(1);
                state   <= TX_DATA;
              end
            end
          end
          RX_DATA: if (scl_rise) begin
            shift_q <= rx_byte;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              if (wp_s) begin
                state <= WAIT_STOP;
              end else begin
                wr_done  <= 1'b1;
                ack_hold <= 1'b0;
                state    <= DATA_ACK;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          DATA_ACK: if (scl_fall) begin
            if (!ack_hold) begin
              sda_oe   <= 1'b1;
              ack_hold <= 1'b1;
            end else begin
              sda_oe   <= 1'b0;
              ack_hold <= 1'b0;
              mem_addr <= mem_addr + 1'b1;
              state    <= RX_DATA;
            end
          end
          TX_DATA: if (scl_fall) begin
            // bit_cnt==0 means a fresh byte after a master ACK; load it from memory.
            if (bit_cnt == '0) begin
              sda_oe  <= ~rd_data[0];
              shift_q <= rd_data >> 1;
              bit_cnt <= CNT_W'(1);
            end else if (bit_cnt < CNT_W'(DATA_W)) begin
              sda_oe  <= ~shift_q[0];
              shift_q <= shift_q >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= MST_ACK;
            end
          end
          MST_ACK: if (scl_rise) begin
            rd_done <= 1'b1;
            if (!sda_s) begin
              mem_addr <= mem_addr + 1'b1;
              bit_cnt  <= '0;
              state    <= TX_DATA;
            end else begin
              state <= WAIT_STOP;
            end
          end
          WAIT_STOP: sda_oe <= 1'b0;
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged master, hand-computed expectations.
module tb_i2c_eeprom_slave;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       wp = 1'b0;
  wire        sda;
  logic       busy, wr_done, rd_done;
  logic [6:0] mem_addr;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  pullup (sda);
  assign sda = sda_m ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
`ifdef EEPROM_WRITE_PROTECT_EN
    .wp(wp),
`endif
    .busy(busy), .wr_done(wr_done), .rd_done(rd_done), .mem_addr(mem_addr)
  );

  always @(negedge clk) begin
    if (wr_done) wr_cnt++;
    if (rd_done) rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic m_start();
    if (scl == 1'b0) begin
      sda_m = 1'b1; wait_q(1);
      scl = 1'b1;   wait_q(1);
    end
    sda_m = 1'b0; wait_q(1);
    scl = 1'b0;   wait_q(1);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wait_q(1);
    scl = 1'b1;   wait_q(1);
    sda_m = 1'b1; wait_q(2);
  endtask

  task automatic m_bit(input logic b, output logic r);
    sda_m = b; wait_q(1);
    scl = 1'b1; wait_q(1);
    r = sda;    wait_q(1);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 0; i < 8; i++) m_bit(d[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_rbyte(output logic [7:0] d, input logic ack_bit);
    logic r;
    for (int i = 0; i < 8; i++) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(ack_bit, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         wr0, rd0;

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_wr_done", wr_done, 0);
    check("reset_rd_done", rd_done, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_sda", sda, 1);
    rst = 1'b1;
    wait_q(2);

    // Write 0xA5 to 0x2A
    m_start();
    check("wr_busy", busy, 1);
    m_wbyte(8'h55, ack); check("wr_cmd_ack", ack, 0);
    m_wbyte(8'hA5, ack); check("wr_data_ack", ack, 0);
    check("wr_done_cnt", wr_cnt, 1);
    m_stop();
    check("wr_busy_after_stop", busy, 0);
    check("wr_addr_inc", mem_addr, 7'h2B);

    // Read 0x2A, NACK
    m_start();
    m_wbyte(8'h54, ack); check("rd_cmd_ack", ack, 0);
    check("rd_addr", mem_addr, 7'h2A);
    m_rbyte(d, 1'b1);    check("rd_data", d, 8'hA5);
    check("rd_done_cnt", rd_cnt, 1);
    check("rd_wait_stop_busy", busy, 1);
    m_stop();
    check("rd_busy_after_stop", busy, 0);
    check("rd_addr_nack_hold", mem_addr, 7'h2A);

    // Sequential write with wrap
    wr0 = wr_cnt;
    m_start();
    m_wbyte(8'hFF, ack); check("seqw_cmd_ack", ack, 0);
    m_wbyte(8'h11, ack); check("seqw_ack0", ack, 0);
    check("seqw_wrap_addr", mem_addr, 7'h00);
    m_wbyte(8'h22, ack); check("seqw_ack1", ack, 0);
    m_stop();
    check("seqw_addr", mem_addr, 7'h01);
    check("seqw_wr_cnt", wr_cnt - wr0, 2);

    // Sequential read with wrap
    rd0 = rd_cnt;
    m_start();
    m_wbyte(8'hFE, ack); check("seqr_cmd_ack", ack, 0);
    m_rbyte(d, 1'b0);    check("seqr_byte0", d, 8'h11);
    m_rbyte(d, 1'b1);    check("seqr_byte1", d, 8'h22);
    m_stop();
    check("seqr_rd_cnt", rd_cnt - rd0, 2);
    check("seqr_addr", mem_addr, 7'h00);

    // Repeated START aborts a partial data byte
    wr0 = wr_cnt;
    m_start();
    m_wbyte(8'h55, ack); check("abort_cmd_ack", ack, 0);
    for (int i = 0; i < 4; i++) m_bit(1'b0, r);
    m_start();
    check("abort_addr_kept", mem_addr, 7'h2A);
    m_wbyte(8'h54, ack); check("abort_rd_cmd_ack", ack, 0);
    m_rbyte(d, 1'b1);    check("abort_rd_data", d, 8'hA5);
    m_stop();
    check("abort_no_wr", wr_cnt - wr0, 0);

    // Reset while the slave drives a 0 data bit (bit1 of 0xA5)
    m_start();
    m_wbyte(8'h54, ack);
    m_bit(1'b1, r);      check("rst_bit0", r, 1);
    check("rst_driving_low", sda, 0);
    rst = 1'b0;
    #1;
    check("rst_sda_released", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rd_done", rd_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sda_m = 1'b1;
    scl = 1'b1;
    wait_q(2);
    wr0 = wr_cnt;
    m_start();
    m_wbyte(8'h21, ack); check("post_rst_cmd_ack", ack, 0);
    m_wbyte(8'h5A, ack); check("post_rst_data_ack", ack, 0);
    m_stop();
    check("post_rst_wr_cnt", wr_cnt - wr0, 1);
    m_start();
    m_wbyte(8'h20, ack);
    m_rbyte(d, 1'b1);    check("post_rst_rd", d, 8'h5A);
    m_stop();

`ifdef EEPROM_WRITE_PROTECT_EN
    // Write protect: address ACKed, data NACKed, memory untouched
    wp = 1'b1;
    wait_q(1);
    wr0 = wr_cnt;
    m_start();
    m_wbyte(8'h21, ack); check("wp_cmd_ack", ack, 0);
    m_wbyte(8'h3C, ack); check("wp_data_nack", ack, 1);
    m_stop();
    check("wp_no_wr", wr_cnt - wr0, 0);
    wp = 1'b0;
    wait_q(1);
    m_start();
    m_wbyte(8'h20, ack);
    m_rbyte(d, 1'b1);    check("wp_mem_kept", d, 8'h5A);
    m_stop();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
